// File: rtl/nn_neuron_seq_if.sv
// rtl/nn_neuron_seq_if.sv - input vector and result handshake bundle for nn_neuron_seq
interface nn_neuron_seq_if #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N_IN*DATA_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic                   out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/nn_neuron_seq.sv
// rtl/nn_neuron_seq.sv - time-multiplexed neuron: serial saturating MAC then step/hard-sigmoid/ReLU
module nn_neuron_seq #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 8,
  parameter int WGT_W  = 8,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 8,
  parameter int SIG_SH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(N_IN+1)-1:0]  cfg_addr,
  input  logic signed [WGT_W-1:0]    cfg_wdata,
  output logic                       cfg_err,
  input  logic [1:0]                 act_mode,
  output logic                       busy,
  nn_neuron_seq_if.slave             io
);
  localparam int CA_W  = $clog2(N_IN + 1);
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PRD_W = DATA_W + WGT_W;
  localparam int EW    = ACC_W + 2;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [EW-1:0]    OUT_MAX = EW'((1 << OUT_W) - 1);
  localparam logic signed [EW-1:0]    SIG_OFS = EW'(1 << (OUT_W - 1));

  typedef enum logic [1:0] {IDLE, MAC, ACT, OUT} state_t;
  state_t state, state_nx;

  logic signed [WGT_W-1:0] wgt [N_IN];
  logic signed [WGT_W-1:0] bias;
  logic [N_IN*DATA_W-1:0]  x_q;
  logic [1:0]              mode_q;
  logic signed [ACC_W-1:0] acc;
  logic [IDX_W-1:0]        idx;
  logic                    sat_q;

  logic                    accept;
  logic                    last;
  logic signed [DATA_W-1:0] x_cur;
  logic signed [PRD_W-1:0] prod;
  logic [ACC_W:0]          sum;
  logic                    sum_ovf;
  logic signed [ACC_W-1:0] sum_sat;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [EW-1:0]    act_v;
  logic [OUT_W-1:0]        act_data;
  logic                    act_clamp;

  assign accept       = (state == IDLE) && io.in_valid;
  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == OUT);
  assign busy         = (state != IDLE);
  assign last         = (idx == IDX_W'(N_IN - 1));

  // One extra guard bit on the sum exposes signed overflow of the ACC_W add.
  assign x_cur   = x_q[idx*DATA_W +: DATA_W];
  assign prod    = x_cur * wgt[idx];
  assign sum     = {acc[ACC_W-1], acc} + (ACC_W+1)'(prod);
  assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
  assign sum_sat = !sum_ovf ? sum[ACC_W-1:0] : (sum[ACC_W] ? ACC_MIN : ACC_MAX);
  assign acc_sh  = acc >>> SIG_SH;

  always_comb begin
    act_v     = '0;
    act_data  = '0;
    act_clamp = 1'b0;
    case (mode_q)
      2'd1:    act_v = {{2{acc_sh[ACC_W-1]}}, acc_sh} + SIG_OFS;
      2'd2:    act_v = {{2{acc[ACC_W-1]}}, acc};
      default: act_v = '0;
    endcase
    if (mode_q == 2'd1 || mode_q == 2'd2) begin
      if (act_v < 0) begin
        act_data  = '0;
        act_clamp = 1'b1;
      end else if (act_v > OUT_MAX) begin
        act_data  = '1;
        act_clamp = 1'b1;
      end else begin
        act_data  = act_v[OUT_W-1:0];
      end
    end else begin
      act_data = {{(OUT_W-1){1'b0}}, ~acc[ACC_W-1]};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (io.in_valid) state_nx = MAC;
      MAC:     if (last) state_nx = ACT;
      ACT:     state_nx = OUT;
      OUT:     if (io.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) wgt[i] <= '0;
      bias        <= '0;
      x_q         <= '0;
      mode_q      <= '0;
      acc         <= '0;
      idx         <= '0;
      sat_q       <= 1'b0;
      io.out_data <= '0;
      io.out_sat  <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      // A write racing an accept is dropped so the captured vector sees one consistent weight set.
      if (cfg_we) begin
        if (state == IDLE && !accept && cfg_addr <= CA_W'(N_IN)) begin
          if (cfg_addr == CA_W'(N_IN)) bias <= cfg_wdata;
          else                         wgt[cfg_addr[IDX_W-1:0]] <= cfg_wdata;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      case (state)
        IDLE: if (accept) begin
          x_q    <= io.in_data;
          mode_q <= act_mode;
          acc    <= ACC_W'(bias);
          idx    <= '0;
          sat_q  <= 1'b0;
        end
        MAC: begin
          acc   <= sum_sat;
          sat_q <= sat_q | sum_ovf;
          idx   <= idx + 1'b1;
        end
        ACT: begin
          io.out_data <= act_data;
          io.out_sat  <= sat_q | act_clamp;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nn_neuron_seq.sv
// tb/tb_nn_neuron_seq.sv - scoreboard bench for nn_neuron_seq (2-input main instance, 4-input saturation instance)
module tb_nn_neuron_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  logic             cfg_we0, cfg_err0, busy0;
  logic [1:0]       cfg_addr0, act_mode0;
  logic signed [7:0] cfg_wdata0;
  nn_neuron_seq_if #(.N_IN(2), .DATA_W(8), .OUT_W(8)) b0 ();

  nn_neuron_seq #(.N_IN(2), .DATA_W(8), .WGT_W(8), .ACC_W(20), .OUT_W(8), .SIG_SH(2)) u0 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we0), .cfg_addr(cfg_addr0), .cfg_wdata(cfg_wdata0),
    .cfg_err(cfg_err0), .act_mode(act_mode0), .busy(busy0), .io(b0)
  );

  logic             cfg_we1, cfg_err1, busy1;
  logic [2:0]       cfg_addr1;
  logic [1:0]       act_mode1;
  logic signed [7:0] cfg_wdata1;
  nn_neuron_seq_if #(.N_IN(4), .DATA_W(8), .OUT_W(8)) b1 ();

  nn_neuron_seq #(.N_IN(4), .DATA_W(8), .WGT_W(8), .ACC_W(16), .OUT_W(8), .SIG_SH(2)) u1 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we1), .cfg_addr(cfg_addr1), .cfg_wdata(cfg_wdata1),
    .cfg_err(cfg_err1), .act_mode(act_mode1), .busy(busy1), .io(b1)
  );

  typedef logic [8:0] exp_t;
  exp_t exp_q[$];
  int cw0, cw1, cb;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && b0.out_valid && b0.out_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("out_data", b0.out_data, e[7:0]);
        check("out_sat", b0.out_sat, e[8]);
      end
    end
  end

  function automatic int floor4(input int a);
    return (a >= 0) ? a / 4 : -((-a + 3) / 4);
  endfunction

  function automatic exp_t model(input int x0, input int x1, input int mode);
    int acc, v;
    bit sat, clamp;
    int xs[2];
    int ws[2];
    xs[0] = x0; xs[1] = x1; ws[0] = cw0; ws[1] = cw1;
    acc = cb; sat = 0; clamp = 0;
    for (int i = 0; i < 2; i++) begin
      acc = acc + xs[i] * ws[i];
      if (acc > 524287)  begin acc = 524287;  sat = 1; end
      if (acc < -524288) begin acc = -524288; sat = 1; end
    end
    if (mode == 1 || mode == 2) begin
      v = (mode == 1) ? floor4(acc) + 128 : acc;
      if (v < 0)   begin v = 0;   clamp = 1; end
      if (v > 255) begin v = 255; clamp = 1; end
    end else begin
      v = (acc >= 0) ? 1 : 0;
    end
    return {sat | clamp, v[7:0]};
  endfunction

  function automatic logic [15:0] pk(input int x0, input int x1);
    return {x1[7:0], x0[7:0]};
  endfunction

  task automatic cfg0(input int addr, input int data, input int exp_err);
    cfg_we0 = 1'b1; cfg_addr0 = addr[1:0]; cfg_wdata0 = data[7:0];
    @(posedge clk); #1;
    cfg_we0 = 1'b0;
    check("cfg_err", cfg_err0, exp_err);
  endtask

  task automatic send0(input int x0, input int x1, input int mode,
                       input int exp_d, input int exp_s, input bit poke);
    int k;
    int tmo;
    exp_t e;
    tmo = 0;
    while (!b0.in_ready && tmo < 50) begin @(posedge clk); #1; tmo++; end
    check("in_ready_wait", b0.in_ready, 1);
    b0.in_valid = 1'b1; b0.in_data = pk(x0, x1); act_mode0 = mode[1:0];
    e = {exp_s[0], exp_d[7:0]};
    exp_q.push_back(e);
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
    check("busy_after_accept", busy0, 1);
    k = 0;
    if (poke) begin
      cfg_we0 = 1'b1; cfg_addr0 = 2'd0; cfg_wdata0 = -8'sd100;
      @(posedge clk); #1;
      cfg_we0 = 1'b0; k = 1;
      check("cfg_err_busy", cfg_err0, 1);
    end
    while (!b0.out_valid && k < 20) begin @(posedge clk); #1; k++; end
    check("latency", k, 3);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    exp_t e;
    rst_n = 1'b0;
    cfg_we0 = 0; cfg_addr0 = 0; cfg_wdata0 = 0; act_mode0 = 0;
    cfg_we1 = 0; cfg_addr1 = 0; cfg_wdata1 = 0; act_mode1 = 0;
    b0.in_valid = 0; b0.in_data = 0; b0.out_ready = 1;
    b1.in_valid = 0; b1.in_data = 0; b1.out_ready = 1;
    cw0 = 0; cw1 = 0; cb = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_in_ready", b0.in_ready, 1);
    check("rst_out_valid", b0.out_valid, 0);
    check("rst_busy", busy0, 0);
    check("rst_out_data", b0.out_data, 0);
    check("rst_out_sat", b0.out_sat, 0);
    check("rst_cfg_err", cfg_err0, 0);

    // Saturating 16-bit accumulator instance: positive then negative overflow.
    for (int p = 0; p < 2; p++) begin
      cfg_we1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
        cfg_addr1 = i[2:0]; cfg_wdata1 = (p == 0) ? -8'sd128 : 8'sd127;
        @(posedge clk); #1;
      end
      cfg_addr1 = 3'd4; cfg_wdata1 = 0;
      @(posedge clk); #1;
      cfg_we1 = 1'b0;
      b1.in_valid = 1'b1; b1.in_data = {4{8'h80}}; act_mode1 = (p == 0) ? 2'd2 : 2'd1;
      @(posedge clk); #1;
      b1.in_valid = 1'b0;
      k = 0;
      while (!b1.out_valid && k < 30) begin @(posedge clk); #1; k++; end
      check("sat_latency", k, 5);
      check("sat_out_data", b1.out_data, (p == 0) ? 255 : 0);
      check("sat_out_sat", b1.out_sat, 1);
      @(posedge clk); #1;
    end

    cfg0(0, 20, 0); cfg0(1, 20, 0); cfg0(2, -30, 0);
    cw0 = 20; cw1 = 20; cb = -30;

    send0(0, 0, 0, 0, 0, 0);
    send0(0, 1, 0, 0, 0, 0);
    send0(1, 0, 0, 0, 0, 0);
    send0(1, 1, 0, 1, 0, 0);
    send0(1, 1, 1, 130, 0, 0);
    send0(0, 0, 1, 120, 0, 0);
    send0(0, 1, 1, 125, 0, 0);
    send0(1, 1, 2, 10, 0, 0);
    send0(0, 0, 2, 0, 1, 0);
    send0(1, 1, 3, 1, 0, 0);

    send0(1, 1, 2, 10, 0, 1);
    cfg0(3, 5, 1);
    send0(1, 1, 2, 10, 0, 0);

    // Backpressure: result held, extra in_valid ignored while OUT.
    b0.out_ready = 1'b0;
    b0.in_valid = 1'b1; b0.in_data = pk(1, 1); act_mode0 = 2'd0;
    e = {1'b0, 8'd1};
    exp_q.push_back(e);
    @(posedge clk); #1;
    b0.in_data = pk(0, 0);
    k = 0;
    while (!b0.out_valid && k < 20) begin @(posedge clk); #1; k++; end
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", b0.out_valid, 1);
      check("bp_out_data", b0.out_data, 1);
      check("bp_in_ready", b0.in_ready, 0);
      @(posedge clk); #1;
    end
    b0.in_valid = 1'b0; b0.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_released", b0.out_valid, 0);

    for (int r = 0; r < 3; r++) begin
      cw0 = int'($urandom_range(0, 255)) - 128;
      cw1 = int'($urandom_range(0, 255)) - 128;
      cb  = int'($urandom_range(0, 255)) - 128;
      cfg0(0, cw0, 0); cfg0(1, cw1, 0); cfg0(2, cb, 0);
      for (int v = 0; v < 3; v++) begin
        int x0, x1, m;
        x0 = int'($urandom_range(0, 255)) - 128;
        x1 = int'($urandom_range(0, 255)) - 128;
        m  = int'($urandom_range(0, 3));
        e  = model(x0, x1, m);
        send0(x0, x1, m, e[7:0], e[8], 0);
      end
    end

    // Reset mid-MAC: operation discarded, weights cleared.
    b0.in_valid = 1'b1; b0.in_data = pk(1, 1); act_mode0 = 2'd2;
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_out_valid", b0.out_valid, 0);
    check("rst_mid_busy", busy0, 0);
    rst_n = 1'b1;
    check("rst_mid_in_ready", b0.in_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    cw0 = 0; cw1 = 0; cb = 0;
    send0(1, 1, 2, 0, 0, 0);
    send0(0, 0, 0, 1, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
